// File: rtl/reset_sequencer.sv
// Staged reset controller: synchronizes board reset deassertion, holds all
// downstream domains in reset, then releases the stage outputs one by one.
// Soft resets are accepted through a req/ack handshake once fully running.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  clk_sync,
  input  logic                  reset_async_n,
  input  logic                  soft_reset_req,
  output logic                  soft_reset_ack,
  output logic [NUM_STAGES-1:0] reset_stage_n,
  output logic                  ready
);

  localparam int unsigned IDX_W   = $clog2(NUM_STAGES + 1);
  localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES - 1 : STAGE_GAP - 1;

  // Parameter sanity checks at elaboration
  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("reset_sequencer: NUM_STAGES must be at least 1");
  end
  if (HOLD_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_timing
    $error("reset_sequencer: HOLD_CYCLES and STAGE_GAP must be at least 1");
  end
  if ((MAX_CNT >> CNT_WIDTH) != 0) begin : g_bad_width
    $error("reset_sequencer: CNT_WIDTH too small for HOLD_CYCLES/STAGE_GAP");
  end

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  logic                  sync_buf;
  logic                  rst_sync;
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;

  // Two-flop synchronizer: assertion is immediate, deassertion is clocked
  always_ff @(posedge clk_sync or negedge reset_async_n) begin
    if (!reset_async_n) begin
      sync_buf <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      sync_buf <= 1'b1;
      rst_sync <= sync_buf;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_sync or negedge reset_async_n) begin
    if (!reset_async_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state, counter, stage-release and handshake logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        if (!rst_sync) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_WIDTH'(HOLD_CYCLES - 1)) begin
          stage_d[0] = 1'b1;
          cnt_d      = '0;
          idx_d      = IDX_W'(1);
          if (NUM_STAGES == 1) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (cnt_q == CNT_WIDTH'(STAGE_GAP - 1)) begin
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (IDX_W'(i) == idx_q) stage_d[i] = 1'b1;
          end
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (soft_reset_req) begin
          stage_d = '0;
          ready_d = 1'b0;
          ack_d   = 1'b1;
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign reset_stage_n  = stage_q;
  assign ready          = ready_q;
  assign soft_reset_ack = ack_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Staged reset controller driven by one board-level asynchronous active-low reset.
- Internally synchronizes reset deassertion with a two-flop synchronizer.
- Holds every downstream domain in reset for a programmable interval, then releases NUM_STAGES reset outputs one at a time in index order, spaced by a programmable gap.
- Accepts soft-reset requests through a req/ack handshake and re-runs the full sequence; sits at the top level between the board reset pin and all functional blocks.

Parameters:
- NUM_STAGES, 4, number of staged reset outputs (>=1).
- HOLD_CYCLES, 16, cycles all stages stay asserted after the synchronized reset releases or a soft reset is accepted (>=1).
- STAGE_GAP, 8, cycles between release of stage k and stage k+1 (>=1).
- CNT_WIDTH, 8, counter width; must hold max(HOLD_CYCLES, STAGE_GAP)-1. Violations are flagged at elaboration.

Ports:
- clk_sync  input  1  sequencing clock.
- reset_async_n  input  1  asynchronous, active-low reset. Assertion is immediate; deassertion is synchronized internally.
- soft_reset_req  input  1  level request to re-run the reset sequence.
- soft_reset_ack  output  1  one-cycle pulse when a soft request is accepted.
- reset_stage_n  output  NUM_STAGES  active-low resets. Bit 0 releases first.
- ready  output  1  high when all stages are released.

Behaviour:
- reset_async_n low, asynchronously and at once:
  - reset_stage_n = all 0, ready = 0, soft_reset_ack = 0.
  - Both synchronizer flops = 0, state = HOLD, counter = 0, stage index = 0.
- Synchronizer: buffer flop loads 1 each edge; rst_sync loads the buffer. rst_sync becomes 1 at edge 2 after deassertion (edges counted from the first rising edge after reset_async_n rises). While rst_sync = 0, the FSM stays in HOLD with counter = 0.
- HOLD: counts edges at which registered rst_sync = 1. When counter == HOLD_CYCLES-1 at an edge, that edge sets reset_stage_n[0] = 1, counter = 0, idx = 1, and moves to:
  - RUN if NUM_STAGES == 1, with ready = 1;
  - RELEASE otherwise.
- RELEASE: counter increments each edge. When counter == STAGE_GAP-1, that edge sets reset_stage_n[idx] = 1, increments idx and clears counter. Releasing the last stage moves to RUN, with ready = 1 at the same edge.
- Power-on timing: stage k rises at edge 2 + HOLD_CYCLES + k*STAGE_GAP.
- Released bits stay 1 until the next assertion. Assertion is always all stages at once, never staged.
- RUN: soft_reset_req is sampled each edge. If it is 1 at edge e:
  - at edge e: reset_stage_n = all 0, ready = 0, soft_reset_ack = 1, state = HOLD, counter = 0, idx = 0;
  - at edge e+1: ack = 0;
  - the sequence restarts; stage k rises at edge e + HOLD_CYCLES + k*STAGE_GAP.
- soft_reset_req is ignored (no ack, no effect) in HOLD and RELEASE. Requests are not queued.
- The requester must drop req after seeing ack. If req is still high on the first RUN edge, it is accepted again.
- Simultaneous reset_async_n assertion and soft_reset_req: the async reset wins and no ack is issued.
- reset_async_n asserted mid-sequence: everything clears immediately. After deassertion, the full sequence restarts from edge 1 with no partial state kept.
- soft_reset_ack and ready are registered. No combinational path runs from inputs to outputs except the async clear.

Test Plan:
- Power-on (defaults): release reset_async_n between edges -> reset_stage_n[0..3] rise at edges 18, 26, 34, 42; ready rises at edge 42; no intermediate glitches.
- Soft reset: in RUN, hold soft_reset_req high until ack -> at acceptance edge e, all stages 0, ready 0, ack high for exactly 1 cycle; stages rise at e+16, e+24, e+32, e+40.
- Ignored request: pulse soft_reset_req for 3 cycles while stage 1 is pending -> no ack, release timing unchanged. Req held high through RUN entry -> accepted at the first RUN edge.
- Async reset mid-RELEASE: pull reset_async_n low after stage 1 rises -> all outputs 0 within the same cycle (no clock needed); after release, stage 0 rises at edge 18 again.
- Parameter override NUM_STAGES=1, HOLD_CYCLES=1, STAGE_GAP=1 -> reset_stage_n[0] and ready rise at edge 3. A soft reset accepted at edge e re-releases at edge e+1.
- Async reset asserted on the same edge as soft_reset_req in RUN -> no ack pulse, outputs cleared, normal power-on timing follows.
